keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter DWELLCYC, default 100000, meaning clock cycles each column is driven before its rows are sampled (>=2).
REQ-002 The block SHALL have parameter DBCYC, default 500000, meaning clock cycles of stable row pattern required for press or release (>=2).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port row  input  4  raw keypad rows, active-low (pulled up), asynchronous to clk.
REQ-006 The block SHALL have port col  output  4  keypad column drive, active-low one-hot.
REQ-007 The block SHALL have port key  output  4  code of last accepted key: row_index*4 + col_index.
REQ-008 The block SHALL have port key_valid  output  1  single-cycle pulse on each accepted press.
REQ-009 The block SHALL have port key_down  output  1  level, high while the accepted key is held.

Function
REQ-010 The block SHALL pass row through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rs).
REQ-011 The block SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 The block SHALL drive col = ~(4'b0001 << col_idx) in every state, with col_idx changing only in SCAN or on RELEASE exit.
REQ-013 In SCAN, the block SHALL count DWELLCYC cycles and, on the last one, sample rs.
REQ-014 In SCAN, on a sample with rs == 4'hF, the block SHALL advance col_idx (3 wraps to 0), restart the dwell count, and stay in SCAN.
REQ-015 In SCAN, on a sample with any rs bit low, the block SHALL capture rs as pat and enter DEBOUNCE with col_idx frozen.
REQ-016 In DEBOUNCE, the block SHALL count cycles with rs == pat; any rs != pat SHALL return to SCAN on the same col_idx with the dwell count restarted.
REQ-017 When DEBOUNCE reaches DBCYC stable cycles, the block SHALL, on the next edge, load key, pulse key_valid for one cycle, set key_down, and enter HELD.
REQ-018 When several rows are low in pat, the block SHALL encode the lowest-indexed low row.
REQ-019 In HELD, rs == 4'hF SHALL enter RELEASE; in RELEASE, any low rs bit SHALL return to HELD with the count cleared.
REQ-020 When RELEASE reaches DBCYC consecutive cycles of rs == 4'hF, the block SHALL clear key_down, advance col_idx with wrap, and enter SCAN.
REQ-021 The block SHALL hold key between presses, SHALL NOT re-pulse key_valid while held (no auto-repeat), and SHALL produce exactly one key_valid per accepted press.
REQ-022 The block SHALL size counters to ceil(log2(max(DWELLCYC, DBCYC)+1)) bits, and they SHALL never wrap.

Reset
REQ-023 While reset is low, the block SHALL immediately force state=SCAN, col_idx=0, col=4'b1110, key=0, key_valid=0, key_down=0, synchronizer flops=4'hF, pat=4'hF, and all counters=0.
REQ-024 A reset asserted mid-press or mid-debounce SHALL discard the press; after release the block SHALL start a full dwell on column 0.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum and the row-to-index priority encode function.
REQ-026 The block SHALL instantiate one Synchronizer (NUMBITS=4) for row; the FSM and counters SHALL remain inline.

Verification (DWELLCYC=4, DBCYC=8)
REQ-027 Reset with rows=4'hF -> col=1110 during reset; after release col steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid never pulses.
REQ-028 Hold row2 low (4'b1011) while col1 is driven, for 40 cycles, then release -> one key_valid pulse, key=4'h9, key_down high until 8 stable-high cycles after release, then low and col advances to 1011.
REQ-029 Toggle row0 every 3 cycles during col0, then hold it low -> no pulse while bouncing; exactly one pulse with key=4'h0 after 8 stable cycles.
REQ-030 Hold rows 1 and 3 low together at col0 -> key=4'h4, single pulse.
REQ-031 Drop reset during HELD -> col=1110, key=0, key_down=0 at once; held key after reset release -> new press accepted only after a full dwell and debounce.
REQ-032 Hold row3 at col3 -> key=4'hF; after release, scanning resumes at col0 (1110).

Source files
------------

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner.
//   state_e   : scanner FSM states
//   ROWS_IDLE : synchronized row pattern with no key pulling a row low
//   rowIndex  : priority encode of an active-low row pattern to a row index
// ---------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // Rows are active-low. When several rows are low the lowest-indexed one
    // wins, so the loop walks downward and the last hit is the lowest index.
    function automatic logic [1:0] rowIndex(input logic [3:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!pat[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/Synchronizer.sv
// ---------------------------------------------------------------------------
// Synchronizer
// Two-flop synchronizer for a bus of independent asynchronous bits.
//   clk   : destination clock
//   reset : asynchronous, active-low; both stages load RESETVAL
//   d_i   : asynchronous input bits
//   q_o   : synchronized output bits (second stage)
// ---------------------------------------------------------------------------
module Synchronizer #(
    parameter int                 NUMBITS  = 4,
    parameter logic [NUMBITS-1:0] RESETVAL = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUMBITS-1:0] d_i,
    output logic [NUMBITS-1:0] q_o
);

    logic [NUMBITS-1:0] stage1_q;
    logic [NUMBITS-1:0] stage2_q;

    // Both stages reset to the idle level so the consumer sees no activity
    // while the first real samples work their way through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage1_q <= RESETVAL;
            stage2_q <= RESETVAL;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// presses and releases, and reports one code per accepted press.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low
//   row       : raw keypad rows, active-low, asynchronous to clk
//   col       : column drive, active-low one-hot
//   key       : last accepted key code, row_index*4 + col_index
//   key_valid : one-cycle pulse per accepted press
//   key_down  : high while the accepted key is held
// Parameters:
//   DWELLCYC  : cycles each column is driven before rows are sampled
//   DBCYC     : stable cycles required to accept a press or a release
// ---------------------------------------------------------------------------
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DWELLCYC = 100000,
    parameter int DBCYC    = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam int MAXCYC = (DWELLCYC > DBCYC) ? DWELLCYC : DBCYC;
    localparam int CNTW   = $clog2(MAXCYC + 1);

    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELLCYC - 1);
    localparam logic [CNTW-1:0] DB_LAST    = CNTW'(DBCYC - 1);

    logic [3:0]      rs;

    state_e          state_q,  state_d;
    logic [1:0]      colIdx_q, colIdx_d;
    logic [3:0]      pat_q,    pat_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;
    logic [3:0]      key_q,    key_d;
    logic            keyValid_q, keyValid_d;
    logic            keyDown_q,  keyDown_d;

    Synchronizer #(
        .NUMBITS  (4),
        .RESETVAL (ROWS_IDLE)
    ) u_rowSync (
        .clk   (clk),
        .reset (reset),
        .d_i   (row),
        .q_o   (rs)
    );

    // State and datapath registers. Reset discards any press in flight and
    // restarts scanning with a full dwell on column 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SCAN;
            colIdx_q   <= 2'd0;
            pat_q      <= ROWS_IDLE;
            cnt_q      <= '0;
            key_q      <= 4'd0;
            keyValid_q <= 1'b0;
            keyDown_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            colIdx_q   <= colIdx_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            keyValid_q <= keyValid_d;
            keyDown_q  <= keyDown_d;
        end
    end

    // Next-state logic. One shared counter serves as the dwell timer in SCAN
    // and the stability counter in DEBOUNCE and RELEASE; every path that
    // changes state clears it, and its terminal values never exceed MAXCYC-1.
    always_comb begin
        state_d    = state_q;
        colIdx_d   = colIdx_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        keyValid_d = 1'b0;
        keyDown_d  = keyDown_q;

        case (state_q)
            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (rs == ROWS_IDLE) begin
                        colIdx_d = colIdx_q + 2'd1;
                    end else begin
                        pat_d   = rs;
                        state_d = DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (rs != pat_q) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    key_d      = {rowIndex(pat_q), colIdx_q};
                    keyValid_d = 1'b1;
                    keyDown_d  = 1'b1;
                    state_d    = HELD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HELD: begin
                if (rs == ROWS_IDLE) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end

            RELEASE: begin
                if (rs != ROWS_IDLE) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    keyDown_d = 1'b0;
                    colIdx_d  = colIdx_q + 2'd1;
                    state_d   = SCAN;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    assign col       = ~(4'b0001 << colIdx_q);
    assign key       = key_q;
    assign key_valid = keyValid_q;
    assign key_down  = keyDown_q;

endmodule

// File: tb/tb_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan
// Scoreboard bench for keypad_scan. A behavioural 4x4 keypad turns a matrix
// of pressed keys plus the DUT column drive into row levels. Each press
// pushes the code the keypad rules predict; a monitor pops on every
// key_valid pulse and compares.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int DWELL = 4;
    localparam int DB    = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_down;

    logic [15:0] pressed = '0;
    logic [3:0]  expQ[$];
    logic        prevValid = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .DWELLCYC (DWELL),
        .DBCYC    (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Keypad matrix: a pressed key at (r, c) pulls row r low only while
    // column c is being driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Lowest-numbered pressed row in the column gives the code.
    function automatic logic [3:0] expectedCode(input int c, input logic [3:0] mask);
        for (int r = 0; r < 4; r++) begin
            if (mask[r]) begin
                return 4'(r * 4 + c);
            end
        end
        return 4'(c);
    endfunction

    function automatic logic [15:0] keysOf(input int c, input logic [3:0] mask);
        logic [15:0] k;
        k = '0;
        for (int r = 0; r < 4; r++) begin
            if (mask[r]) begin
                k[r*4+c] = 1'b1;
            end
        end
        return k;
    endfunction

    // Monitor: every key_valid pulse must match the oldest pending press,
    // arrive with key_down set, and last exactly one cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (key_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious key_valid", 8'(key_valid), 8'd0);
                end else begin
                    checkOutput("key code", 8'(key), 8'(expQ.pop_front()));
                end
                checkOutput("key_down at pulse", 8'(key_down), 8'd1);
                checkOutput("key_valid width", 8'(prevValid), 8'd0);
            end
            prevValid = key_valid;
        end else begin
            prevValid = 1'b0;
        end
    end

    task automatic waitDrain();
        for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("press accepted", 8'(expQ.size()), 8'd0);
    endtask

    task automatic releaseKey(input int c, input logic [15:0] keys,
                              input logic [3:0] code, input bit bounceOut);
        logic [3:0] expCol;
        if (bounceOut) begin
            for (int i = 0; i < 4; i++) begin
                pressed = pressed ^ keys;
                repeat (2) @(negedge clk);
            end
            pressed = '0;
        end else begin
            pressed = '0;
            repeat (5) @(negedge clk);
            checkOutput("key_down during release debounce", 8'(key_down), 8'd1);
        end
        for (int i = 0; i < 100 && key_down; i++) begin
            @(negedge clk);
        end
        checkOutput("key_down released", 8'(key_down), 8'd0);
        expCol = ~(4'b0001 << ((c + 1) % 4));
        checkOutput("col after release", 8'(col), 8'(expCol));
        checkOutput("key held after release", 8'(key), 8'(code));
    endtask

    task automatic applyStimulus(input int c, input logic [3:0] mask,
                                 input bit bounceIn, input bit bounceOut);
        logic [15:0] keys;
        logic [3:0]  code;
        keys = keysOf(c, mask);
        code = expectedCode(c, mask);
        @(negedge clk);
        if (bounceIn) begin
            for (int i = 0; i < 8; i++) begin
                pressed = pressed ^ keys;
                repeat (3) @(negedge clk);
            end
        end
        expQ.push_back(code);
        pressed = keys;
        waitDrain();
        repeat ($urandom_range(2, 10)) @(negedge clk);
        checkOutput("key_down while held", 8'(key_down), 8'd1);
        checkOutput("key while held", 8'(key), 8'(code));
        releaseKey(c, keys, code, bounceOut);
        repeat ($urandom_range(0, 8)) @(negedge clk);
    endtask

    task automatic resetDuringHeld();
        logic [15:0] keys;
        logic [3:0]  code;
        keys = keysOf(2, 4'b0010);
        code = expectedCode(2, 4'b0010);
        @(negedge clk);
        expQ.push_back(code);
        pressed = keys;
        waitDrain();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset mid-press col", 8'(col), 8'h0E);
        checkOutput("reset mid-press key", 8'(key), 8'h00);
        checkOutput("reset mid-press key_down", 8'(key_down), 8'd0);
        checkOutput("reset mid-press key_valid", 8'(key_valid), 8'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // Column 0 must dwell fully and the key (column 2) then needs a
        // further dwell and debounce, so nothing may pulse this early.
        repeat (10) @(negedge clk);
        expQ.push_back(code);
        waitDrain();
        releaseKey(2, keys, code, 1'b0);
    endtask

    initial begin
        logic [3:0] expCol;
        int         c;
        logic [3:0] mask;

        repeat (3) @(negedge clk);
        checkOutput("reset col", 8'(col), 8'h0E);
        checkOutput("reset key", 8'(key), 8'h00);
        checkOutput("reset key_valid", 8'(key_valid), 8'd0);
        checkOutput("reset key_down", 8'(key_down), 8'd0);

        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k % 4 == 2) begin
                expCol = ~(4'b0001 << ((k / 4) % 4));
                checkOutput("idle scan col", 8'(col), 8'(expCol));
            end
        end

        applyStimulus(1, 4'b0100, 1'b0, 1'b0);
        applyStimulus(0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(0, 4'b1010, 1'b0, 1'b1);
        applyStimulus(3, 4'b1000, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            c    = int'($urandom_range(0, 3));
            mask = 4'($urandom_range(1, 15));
            applyStimulus(c, mask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        resetDuringHeld();

        repeat (30) @(negedge clk);
        checkOutput("leftover expectations", 8'(expQ.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
